frame_out_fifo: RTL and testbench
=================================

// Module: frame_out_fifo
// PURPOSE
//  Output buffer directly downstream of the frame generator. Captures the generator's
//  en_out/dat_out word stream into a synchronous FIFO and drains it over a valid/ready interface.
//  Drives the generator's fifo_full input early enough to absorb the words still in its pipeline.
//  Flags any word lost to a true overflow.
// PARAMETERS
//  DW            16  data word width (matches generator dat_out)
//  AW            5   address width; DEPTH = 2**AW = 32 words
//  AFULL_MARGIN  6   free slots kept in reserve when fifo_full asserts (>= generator in-flight words)
// PORTS
//  clk        in   1     system clock
//  reset_n    in   1     asynchronous active-low reset
//  flush      in   1     sync clear of pointers, count and overflow (tie to update_flag path)
//  en_in      in   1     write strobe (generator en_out)
//  dat_in     in   DW    write data (generator dat_out)
//  fifo_full  out  1     registered almost-full back-pressure to the generator
//  dout       out  DW    head-of-FIFO word (first-word-fall-through)
//  dout_valid out  1     dout holds a valid word
//  dout_ready in   1     consumer accepts dout this cycle
//  level      out  AW+1  current occupancy, 0..DEPTH
//  overflow   out  1     sticky: a word arrived with no free slot and was dropped
// BEHAVIOUR
//  Reset (async, reset_n low): rd_ptr, wr_ptr and count are 0. Outputs: fifo_full=0,
//   dout_valid=0, level=0, overflow=0, dout=0.
//  Storage: DEPTH x DW register array, no reset required on contents.
//   Pointers are AW bits and wrap naturally from DEPTH-1 to 0.
//   count is AW+1 bits.
//  rd  = dout_valid && dout_ready.
//  wr  = en_in && (count < DEPTH || rd).
//   - A simultaneous read frees the slot, so a write at full is accepted when rd=1.
//  drop = en_in && !wr.
//   - The word is discarded, pointers are unchanged, and overflow sets to 1 on the next edge.
//  count_next = count + wr - rd.
//   - Write and read in the same cycle leave count unchanged.
//   - A write into an empty FIFO leaves rd=0 that cycle, so count increments.
//  dout_valid = (count != 0). dout = mem[rd_ptr], combinational from the array.
//   - A word written at edge N is on dout with dout_valid=1 during cycle N+1 (1-cycle latency).
//  level = count.
//  fifo_full is registered: fifo_full <= (count_next >= DEPTH-AFULL_MARGIN).
//   - Default threshold is 26 words. It deasserts on the edge where count_next drops below 26.
//  Margin rationale: the generator samples fifo_full through one register and stops issuing
//   reads the cycle after. Its 2-stage output pipeline still delivers up to 4 words after that.
//   AFULL_MARGIN=6 covers these 4 words with 2 spare.
//  flush (synchronous, highest priority after reset):
//   - rd_ptr=wr_ptr=count=0, overflow=0, fifo_full=0 on the next edge.
//   - en_in and rd in that cycle are ignored.
//  overflow: clears only on reset_n or flush.
//  No FSM. The control state is count/pointers with three conditions:
//   - empty: count==0
//   - almost-full: count >= DEPTH-AFULL_MARGIN
//   - full: count==DEPTH
// TESTING
//  1 Reset then 1 write of 16'hA5A5 -> next cycle dout_valid=1, dout=16'hA5A5, level=1.
//    Read with dout_ready=1 -> level=0, dout_valid=0.
//  2 dout_ready=0, write 26 words 0..25 -> fifo_full rises the edge after word 25.
//    Write 6 more -> level=32, overflow=0.
//    A 33rd write -> dropped, overflow=1, level stays 32.
//  3 At level=32 assert en_in and dout_ready together (data 16'h1234) -> level stays 32,
//    overflow=0, 16'h1234 is read out last.
//  4 Continuous write+read for 100 cycles with an incrementing pattern -> output sequence
//    is identical and in order; pointers wrap past 31 with no gap or duplicate.
//  5 With level=20 and overflow=1, pulse flush with en_in=1 -> next cycle level=0,
//    dout_valid=0, overflow=0, fifo_full=0; the en_in word is not stored.
//  6 Assert reset_n low mid-stream at level=10 -> outputs are at reset values immediately
//    (async); after release, the first new write appears at dout with 1-cycle latency.

Source files
------------

// File: rtl/frame_out_fifo.sv
// First-word-fall-through output FIFO between the frame generator and its consumer.
// Raises a registered almost-full early enough to absorb the generator's in-flight words.
module frame_out_fifo #(
    parameter int DW           = 16,
    parameter int AW           = 5,
    parameter int AFULL_MARGIN = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          en_in,
    input  logic [DW-1:0] dat_in,
    output logic          fifo_full,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [AW:0]   level,
    output logic          overflow
);
    localparam int           DEPTH    = 2 ** AW;
    localparam logic [AW:0]  DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]  AFULL_TH = (AW+1)'(DEPTH - AFULL_MARGIN);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [AW:0]   count_reg, count_next;
    logic          fifo_full_reg, overflow_reg;
    logic          rd, wr, drop;

    // A read in the same cycle frees a slot, so a write at full still lands.
    assign rd   = dout_valid && dout_ready;
    assign wr   = en_in && ((count_reg < DEPTH_C) || rd);
    assign drop = en_in && !wr;

    always_comb begin
        count_next = count_reg;
        case ({wr, rd})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            fifo_full_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else if (flush) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            fifo_full_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            if (wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg     <= count_next;
            fifo_full_reg <= (count_next >= AFULL_TH);
            if (drop) overflow_reg <= 1'b1;
        end
    end

    // Storage carries no reset; dout is gated so it reads zero while empty.
    always_ff @(posedge clk) begin
        if (wr && !flush) mem[wr_ptr_reg] <= dat_in;
    end

    assign dout_valid = (count_reg != '0);
    assign dout       = dout_valid ? mem[rd_ptr_reg] : '0;
    assign level      = count_reg;
    assign fifo_full  = fifo_full_reg;
    assign overflow   = overflow_reg;
endmodule

// File: tb/tb_frame_out_fifo.sv
// Directed self-checking bench for frame_out_fifo.
module tb_frame_out_fifo;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        en_in = 1'b0;
    logic [15:0] dat_in = '0;
    logic        fifo_full;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [5:0]  level;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    frame_out_fifo dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .en_in      (en_in),
        .dat_in     (dat_in),
        .fifo_full  (fifo_full),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick();
        n_cmp++; if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", fifo_full); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", dout_valid); end
        n_cmp++; if (level !== 6'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", level); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
        n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL reset_dout got %h want 0000", dout); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        en_in = 1'b1; dat_in = 16'hA5A5;
        tick();
        en_in = 1'b0;
        n_cmp++; if (dout_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b want 1", dout_valid); end
        n_cmp++; if (dout !== 16'hA5A5) begin n_bad++; $display("FAIL single_dout got %h want a5a5", dout); end
        n_cmp++; if (level !== 6'd1) begin n_bad++; $display("FAIL single_level got %0d want 1", level); end
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        n_cmp++; if (level !== 6'd0) begin n_bad++; $display("FAIL single_rd_level got %0d want 0", level); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL single_rd_valid got %b want 0", dout_valid); end
        $display("single write/read done");
    endtask

    task automatic test_fill_overflow;
        dout_ready = 1'b0;
        for (int i = 0; i < 26; i++) begin
            en_in = 1'b1; dat_in = 16'(i);
            tick();
            if (i == 24) begin
                n_cmp++; if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL afull_early got %b want 0 at level %0d", fifo_full, level); end
            end
        end
        n_cmp++; if (fifo_full !== 1'b1) begin n_bad++; $display("FAIL afull_rise got %b want 1", fifo_full); end
        for (int i = 26; i < 32; i++) begin
            dat_in = 16'(i);
            tick();
        end
        n_cmp++; if (level !== 6'd32) begin n_bad++; $display("FAIL fill_level got %0d want 32", level); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_ovf got %b want 0", overflow); end
        dat_in = 16'h0099;
        tick();
        en_in = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL drop_ovf got %b want 1", overflow); end
        n_cmp++; if (level !== 6'd32) begin n_bad++; $display("FAIL drop_level got %0d want 32", level); end
        n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL drop_head got %h want 0000", dout); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        $display("fill/overflow done");
    endtask

    task automatic test_full_rw;
        logic [15:0] exp;
        dout_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            en_in = 1'b1; dat_in = 16'(100 + i);
            tick();
        end
        n_cmp++; if (level !== 6'd32) begin n_bad++; $display("FAIL fullrw_pre_level got %0d want 32", level); end
        n_cmp++; if (dout !== 16'd100) begin n_bad++; $display("FAIL fullrw_head got %h want %h", dout, 16'd100); end
        dat_in = 16'h1234; dout_ready = 1'b1;
        tick();
        en_in = 1'b0;
        n_cmp++; if (level !== 6'd32) begin n_bad++; $display("FAIL fullrw_level got %0d want 32", level); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fullrw_ovf got %b want 0", overflow); end
        for (int k = 0; k < 32; k++) begin
            exp = (k < 31) ? 16'(101 + k) : 16'h1234;
            n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL fullrw_drain%0d got %h want %h", k, dout, exp); end
            tick();
        end
        dout_ready = 1'b0;
        n_cmp++; if (level !== 6'd0) begin n_bad++; $display("FAIL fullrw_empty got %0d want 0", level); end
        $display("write+read at full done");
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp;
        dout_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            en_in = 1'b1; dat_in = 16'(200 + i);
            if (i > 0) begin
                exp = 16'(200 + i - 1);
                n_cmp++; if (dout_valid !== 1'b1 || dout !== exp) begin n_bad++; $display("FAIL b2b%0d got %h/%b want %h/1", i, dout, dout_valid, exp); end
            end
            tick();
        end
        en_in = 1'b0;
        n_cmp++; if (level !== 6'd1) begin n_bad++; $display("FAIL b2b_level got %0d want 1", level); end
        n_cmp++; if (dout !== 16'd299) begin n_bad++; $display("FAIL b2b_last got %h want %h", dout, 16'd299); end
        tick();
        dout_ready = 1'b0;
        n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty got %b want 0", dout_valid); end
        $display("back-to-back done");
    endtask

    task automatic test_flush;
        dout_ready = 1'b0;
        for (int i = 0; i < 33; i++) begin
            en_in = 1'b1; dat_in = 16'(300 + i);
            tick();
        end
        en_in = 1'b0; dout_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        dout_ready = 1'b0;
        n_cmp++; if (level !== 6'd20) begin n_bad++; $display("FAIL flush_pre_level got %0d want 20", level); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL flush_pre_ovf got %b want 1", overflow); end
        flush = 1'b1; en_in = 1'b1; dat_in = 16'hDEAD;
        tick();
        flush = 1'b0; en_in = 1'b0;
        n_cmp++; if (level !== 6'd0) begin n_bad++; $display("FAIL flush_level got %0d want 0", level); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b want 0", dout_valid); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL flush_ovf got %b want 0", overflow); end
        n_cmp++; if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL flush_full got %b want 0", fifo_full); end
        en_in = 1'b1; dat_in = 16'h0777;
        tick();
        en_in = 1'b0;
        n_cmp++; if (dout !== 16'h0777 || level !== 6'd1) begin n_bad++; $display("FAIL flush_after got %h/%0d want 0777/1", dout, level); end
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        $display("flush done");
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 10; i++) begin
            en_in = 1'b1; dat_in = 16'(400 + i);
            tick();
        end
        en_in = 1'b0;
        n_cmp++; if (level !== 6'd10) begin n_bad++; $display("FAIL ar_pre_level got %0d want 10", level); end
        #3 reset_n = 1'b0;
        #1;
        n_cmp++; if (level !== 6'd0 || dout_valid !== 1'b0 || dout !== 16'h0) begin n_bad++; $display("FAIL ar_async got %0d/%b/%h want 0/0/0000", level, dout_valid, dout); end
        n_cmp++; if (fifo_full !== 1'b0 || overflow !== 1'b0) begin n_bad++; $display("FAIL ar_flags got %b/%b want 0/0", fifo_full, overflow); end
        tick();
        reset_n = 1'b1;
        tick();
        en_in = 1'b1; dat_in = 16'hBEEF;
        tick();
        en_in = 1'b0;
        n_cmp++; if (dout_valid !== 1'b1 || dout !== 16'hBEEF || level !== 6'd1) begin n_bad++; $display("FAIL ar_first got %h/%b/%0d want beef/1/1", dout, dout_valid, level); end
        $display("async reset done");
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_rw();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after 200000 time units");
        $fatal(1, "watchdog");
    end
endmodule
